// File: rtl/sw_mainboard_write_strobes.sv
// Main-CPU write decode for the 0x46xx control window: stretched strobes,
// 8-bit addressable output latch and ADC channel latch, all registered on clk_3.
module sw_mainboard_write_strobes #(
  parameter int unsigned STROBE_WIDTH = 1,
  parameter logic [15:0] BASE_ADDR    = 16'h4600
) (
  input  logic        clk_3,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_dout,
  output logic        evggo,
  output logic        evgres,
  output logic        wdclr,
  output logic        irqclr,
  output logic [7:0]  out_latch,
  output logic        nstore,
  output logic        adc_start,
  output logic [1:0]  adc_chan,
  output logic        soundrst
);

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned NUM_STROBES = 7;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STROBE_WIDTH);

  localparam int unsigned S_EVGGO    = 0;
  localparam int unsigned S_EVGRES   = 1;
  localparam int unsigned S_WDCLR    = 2;
  localparam int unsigned S_IRQCLR   = 3;
  localparam int unsigned S_NSTORE   = 4;
  localparam int unsigned S_ADC      = 5;
  localparam int unsigned S_SOUNDRST = 6;

  logic                   accept_c;
  logic                   latch_we_c;
  logic [NUM_STROBES-1:0] hit_c;
  logic [CNT_W-1:0]       cnt_q     [NUM_STROBES];
  logic [CNT_W-1:0]       cnt_nxt_c [NUM_STROBES];
  logic [NUM_STROBES-1:0] strb_q;
  logic                   unused_bits_c;

  // Address bits 4:3 and the low data bits never select anything.
  assign unused_bits_c = ^{cpu_addr[4:3], cpu_dout[6:0]};

  // Decode one accepted write into at most one strobe hit or a latch write.
  always_comb begin
    accept_c   = cpu_wr_en && !cpu_rw && (cpu_addr[15:8] == BASE_ADDR[15:8]);
    hit_c      = '0;
    latch_we_c = 1'b0;
    if (accept_c) begin
      case (cpu_addr[7:5])
        3'd0: hit_c[S_EVGGO]    = 1'b1;
        3'd1: hit_c[S_EVGRES]   = 1'b1;
        3'd2: hit_c[S_WDCLR]    = 1'b1;
        3'd3: hit_c[S_IRQCLR]   = 1'b1;
        3'd4: latch_we_c        = 1'b1;
        3'd5: hit_c[S_NSTORE]   = 1'b1;
        3'd6: hit_c[S_ADC]      = (cpu_addr[1:0] != 2'd3);
        default: hit_c[S_SOUNDRST] = 1'b1;
      endcase
    end
  end

  // Per-strobe down-counter; a hit reloads, so retriggers extend the pulse.
  always_comb begin
    for (int k = 0; k < NUM_STROBES; k++) begin
      cnt_nxt_c[k] = '0;
      if (hit_c[k]) begin
        cnt_nxt_c[k] = RELOAD;
      end else if (cnt_q[k] != '0) begin
        cnt_nxt_c[k] = cnt_q[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_3) begin
    if (reset) begin
      for (int k = 0; k < NUM_STROBES; k++) begin
        cnt_q[k] <= '0;
      end
      strb_q    <= '0;
      out_latch <= 8'h00;
      adc_chan  <= 2'd0;
    end else begin
      for (int k = 0; k < NUM_STROBES; k++) begin
        cnt_q[k]  <= cnt_nxt_c[k];
        strb_q[k] <= (cnt_nxt_c[k] != '0);
      end
      if (latch_we_c) begin
        out_latch[cpu_addr[2:0]] <= cpu_dout[7];
      end
      if (hit_c[S_ADC]) begin
        adc_chan <= cpu_addr[1:0];
      end
    end
  end

  assign evggo     = strb_q[S_EVGGO];
  assign evgres    = strb_q[S_EVGRES];
  assign wdclr     = strb_q[S_WDCLR];
  assign irqclr    = strb_q[S_IRQCLR];
  assign nstore    = strb_q[S_NSTORE];
  assign adc_start = strb_q[S_ADC];
  assign soundrst  = strb_q[S_SOUNDRST];

endmodule

// File: tb/tb_sw_mainboard_write_strobes.sv
// Bench for sw_mainboard_write_strobes: three widths (1, 3, 8) in parallel,
// checked every cycle against a last-write-time model plus literal expectations.
module tb_sw_mainboard_write_strobes;

  logic        clk_3 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic        cpu_wr_en = 1'b0;
  logic [7:0]  cpu_dout = 8'h00;

  // Strobe bit order: evggo, evgres, wdclr, irqclr, nstore, adc_start, soundrst
  logic [6:0] s1, s3, s8;
  logic [7:0] l1, l3, l8;
  logic [1:0] c1, c3, c8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_3 = ~clk_3;

  sw_mainboard_write_strobes #(.STROBE_WIDTH(1), .BASE_ADDR(16'h4600)) u1 (
    .clk_3(clk_3), .reset(reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_wr_en(cpu_wr_en), .cpu_dout(cpu_dout),
    .evggo(s1[0]), .evgres(s1[1]), .wdclr(s1[2]), .irqclr(s1[3]),
    .out_latch(l1), .nstore(s1[4]), .adc_start(s1[5]), .adc_chan(c1),
    .soundrst(s1[6]));

  sw_mainboard_write_strobes #(.STROBE_WIDTH(3), .BASE_ADDR(16'h4600)) u3 (
    .clk_3(clk_3), .reset(reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_wr_en(cpu_wr_en), .cpu_dout(cpu_dout),
    .evggo(s3[0]), .evgres(s3[1]), .wdclr(s3[2]), .irqclr(s3[3]),
    .out_latch(l3), .nstore(s3[4]), .adc_start(s3[5]), .adc_chan(c3),
    .soundrst(s3[6]));

  sw_mainboard_write_strobes #(.STROBE_WIDTH(8), .BASE_ADDR(16'h4600)) u8 (
    .clk_3(clk_3), .reset(reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
    .cpu_wr_en(cpu_wr_en), .cpu_dout(cpu_dout),
    .evggo(s8[0]), .evgres(s8[1]), .wdclr(s8[2]), .irqclr(s8[3]),
    .out_latch(l8), .nstore(s8[4]), .adc_start(s8[5]), .adc_chan(c8),
    .soundrst(s8[6]));

  // Model: a strobe is high at edge c iff its function was last hit at e with c-e < width.
  int          edge_no = 0;
  int          last_hit [8];
  logic [7:0]  m_latch = 8'h00;
  logic [1:0]  m_chan = 2'd0;
  bit          started = 1'b0;

  function automatic logic [6:0] exp_strobes(input int w, input int c);
    logic [6:0] r;
    r = '0;
    for (int f = 0; f < 8; f++) begin
      if (f != 4 && (c - last_hit[f]) < w) begin
        r[(f < 4) ? f : f - 1] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic cmp_inst(input int w, input logic [16:0] got);
    logic [16:0] exp;
    exp = {exp_strobes(w, edge_no), m_latch, m_chan};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL model_w%0d edge %0d got %h exp %h", w, edge_no, got, exp);
    end
  endtask

  initial begin
    for (int f = 0; f < 8; f++) last_hit[f] = -1000;
    forever begin
      @(posedge clk_3);
      edge_no++;
      if (reset) begin
        started = 1'b1;
        for (int f = 0; f < 8; f++) last_hit[f] = -1000;
        m_latch = 8'h00;
        m_chan  = 2'd0;
      end else if (cpu_wr_en && !cpu_rw && cpu_addr[15:8] == 8'h46) begin
        case (cpu_addr[7:5])
          3'd4: m_latch[cpu_addr[2:0]] = cpu_dout[7];
          3'd6: if (cpu_addr[1:0] != 2'd3) begin
                  last_hit[6] = edge_no;
                  m_chan = cpu_addr[1:0];
                end
          default: last_hit[cpu_addr[7:5]] = edge_no;
        endcase
      end
      #1;
      if (started) begin
        cmp_inst(1, {s1, l1, c1});
        cmp_inst(3, {s3, l3, c3});
        cmp_inst(8, {s8, l8, c8});
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Present one bus cycle; it is consumed by the next rising edge.
  task automatic cyc(input logic we, input logic rw, input logic [15:0] a,
                     input logic [7:0] d, input logic rst);
    @(negedge clk_3);
    cpu_wr_en = we;
    cpu_rw    = rw;
    cpu_addr  = a;
    cpu_dout  = d;
    reset     = rst;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
  endtask

  int hi_cnt, first_hi, last_hi;

  initial begin
    // Reset then idle
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
    repeat (20) idle();
    check("idle_strobes", {9'd0, s1}, 16'h0000);
    check("idle_latch", {8'd0, l1}, 16'h0000);
    check("idle_chan", {14'd0, c8}, 16'h0000);

    // Single-cycle WDCLR / IRQCLR, read ignored
    cyc(1'b1, 1'b0, 16'h4640, 8'h00, 1'b0);
    idle();
    check("wdclr_n1", {15'd0, s1[2]}, 16'h0001);
    idle();
    check("wdclr_n2", {15'd0, s1[2]}, 16'h0000);
    cyc(1'b1, 1'b0, 16'h467F, 8'h00, 1'b0);
    idle();
    check("irqclr_n1", {15'd0, s1[3]}, 16'h0001);
    idle();
    check("irqclr_n2", {15'd0, s1[3]}, 16'h0000);
    cyc(1'b1, 1'b1, 16'h4640, 8'h00, 1'b0);
    idle();
    check("wdclr_read", {15'd0, s1[2]}, 16'h0000);
    repeat (8) idle();

    // Retrigger on width 3: writes at N and N+2 give 5 contiguous cycles
    cyc(1'b1, 1'b0, 16'h4600, 8'h00, 1'b0);
    idle();
    cyc(1'b1, 1'b0, 16'h4600, 8'h00, 1'b0);
    hi_cnt = 0; first_hi = -1; last_hi = -1;
    for (int i = 1; i <= 10; i++) begin
      if (i > 2) idle(); else if (i == 2) ; else ;
      if (i <= 2) begin
        // cycles N+1 and N+2 already elapsed via the calls above; sample them in order
      end
    end
    repeat (10) idle();
    // Re-run cleanly with per-cycle sampling
    cyc(1'b1, 1'b0, 16'h4600, 8'h00, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) cyc(1'b1, 1'b0, 16'h4600, 8'h00, 1'b0);
      else idle();
      if (s3[0]) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
    end
    check("retrig_count", 16'(hi_cnt), 16'd5);
    check("retrig_span", 16'(last_hi - first_hi + 1), 16'd5);
    check("retrig_first", 16'(first_hi), 16'd1);

    // Addressable latch
    cyc(1'b1, 1'b0, 16'h4685, 8'h80, 1'b0);
    idle();
    check("latch_a", {8'd0, l1}, 16'h0020);
    cyc(1'b1, 1'b0, 16'h4680, 8'hFF, 1'b0);
    idle();
    check("latch_b", {8'd0, l3}, 16'h0021);
    cyc(1'b1, 1'b0, 16'h4685, 8'h7F, 1'b0);
    idle();
    check("latch_c", {8'd0, l8}, 16'h0001);

    // ADC: channel 2 then channel 3 (ignored)
    cyc(1'b1, 1'b0, 16'h46C2, 8'h00, 1'b0);
    idle();
    check("adc_start_c2", {15'd0, s1[5]}, 16'h0001);
    check("adc_chan_c2", {14'd0, c1}, 16'h0002);
    cyc(1'b1, 1'b0, 16'h46C3, 8'h00, 1'b0);
    idle();
    check("adc_start_c3", {15'd0, s1[5]}, 16'h0000);
    check("adc_chan_c3", {14'd0, c8}, 16'h0002);
    repeat (10) idle();

    // Reset mid-pulse on width 8, with a simultaneous WDCLR write
    cyc(1'b1, 1'b0, 16'h46E0, 8'h00, 1'b0);
    idle();
    check("soundrst_pre", {15'd0, s8[6]}, 16'h0001);
    idle();
    cyc(1'b1, 1'b0, 16'h4640, 8'h00, 1'b1);
    idle();
    check("soundrst_cut", {15'd0, s8[6]}, 16'h0000);
    check("wdclr_blocked", {15'd0, s8[2]}, 16'h0000);
    check("latch_reset", {8'd0, l8}, 16'h0000);
    repeat (5) idle();

    // Randomized traffic, biased into the control window
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[15:8] = 8'h46;
      cyc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) == 0), a,
          8'($urandom), 1'($urandom_range(0, 99) == 0));
    end
    repeat (12) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
